// File: rtl/ofdm_tx_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_tx_pkg
// Shared types and helpers for the OFDM TX subcarrier mapper.
//   cplx_t      : {Im,Re} sample at the default 16-bit component width
//   bin_class_t : classification of an IFFT bin (null / pilot / data)
//   map_state_t : mapper control state
//   LFSR_SEED   : pilot polarity scrambler seed
//   bin_class() : classifies bin b from the mapper geometry
// ----------------------------------------------------------------------------
package ofdm_tx_pkg;

  localparam logic [6:0]  LFSR_SEED = 7'h7F;
  localparam int unsigned CPLX_DW   = 16;

  typedef struct packed {
    logic [CPLX_DW-1:0] im;
    logic [CPLX_DW-1:0] re;
  } cplx_t;

  typedef enum logic [1:0] {
    BIN_NULL,
    BIN_PILOT,
    BIN_DATA
  } bin_class_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAD
  } map_state_t;

  // Bins 1..nused/2 carry logical carriers 0..nused/2-1; the top half of the
  // spectrum (negative frequencies) carries the remaining logical carriers.
  function automatic bin_class_t bin_class(
    input int unsigned b,
    input int unsigned nfft,
    input int unsigned nused,
    input int unsigned spacing,
    input int unsigned offset
  );
    int unsigned half;
    int unsigned k;
    half = nused / 2;
    if ((b == 0) || ((b > half) && (b < (nfft - half)))) begin
      return BIN_NULL;
    end
    if (b <= half) begin
      k = b - 1;
    end else begin
      k = b - (nfft - nused);
    end
    if ((k % spacing) == offset) begin
      return BIN_PILOT;
    end
    return BIN_DATA;
  endfunction

endpackage

// File: rtl/ofdm_pilot_lfsr.sv
// ----------------------------------------------------------------------------
// ofdm_pilot_lfsr
// 802.11 scrambler (x^7 + x^4 + 1) used as the per-symbol pilot polarity
// source. The current output bit selects the polarity of the symbol being
// mapped; one step is taken per symbol.
//   clk, rst : clock, synchronous active-high reset (loads the seed)
//   step     : advance one position
//   reload   : load the seed (wins over step)
//   p_neg    : 1 = pilot polarity -1 for the current symbol
// ----------------------------------------------------------------------------
module ofdm_pilot_lfsr
  import ofdm_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic reload,
  output logic p_neg
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic       fb;

  assign fb    = lfsr_q[6] ^ lfsr_q[3];
  assign p_neg = fb;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reload) begin
      lfsr_d = LFSR_SEED;
    end else if (step) begin
      lfsr_d = {lfsr_q[5:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// ----------------------------------------------------------------------------
// ofdm_subcarrier_mapper
// Maps the modulator sample stream onto NFFT IFFT bins per OFDM symbol, in
// natural bin order: DC/guard nulls, pilots with scrambled polarity, and data
// carriers taken from the input. Checks symbol alignment of the input and
// zero-pads frames that end early.
//   clk, rst          : clock, synchronous active-high reset
//   s_axis_*          : modulator input ({Im,Re}), tlast = last sample of frame
//   s_mod_symb_last   : marks the last data sample of each OFDM symbol
//   m_axis_*          : bin output ({Im,Re}), tlast on bin NFFT-1
//   m_axis_frame_last : bin NFFT-1 of the last symbol of a frame
//   err_symb_align    : pulse on symbol-last marker misplaced or missing
//   err_short_frame   : pulse when a frame ends early and is padded
// ----------------------------------------------------------------------------
module ofdm_subcarrier_mapper
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned NFFT          = 64,
  parameter int unsigned NUSED         = 48,
  parameter int unsigned PILOT_SPACING = 8,
  parameter int unsigned PILOT_OFFSET  = 3,
  parameter int unsigned DW            = 16,
  parameter logic [DW-1:0] SYMBOL_POS  = 16'h7FFF,
  parameter logic [DW-1:0] SYMBOL_NEG  = 16'h8001,
  parameter bit          PILOT_POL_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [2*DW-1:0] s_axis_tdata,
  input  logic          s_axis_tlast,
  input  logic          s_mod_symb_last,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [2*DW-1:0] m_axis_tdata,
  output logic          m_axis_tlast,
  output logic          m_axis_frame_last,
  output logic          err_symb_align,
  output logic          err_short_frame
);

  localparam int unsigned NDATA = NUSED - NUSED / PILOT_SPACING;
  localparam int unsigned BW    = $clog2(NFFT);
  localparam int unsigned DCW   = $clog2(NDATA + 1);

  map_state_t state_q, state_d;
  logic [BW-1:0]   b_q, b_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;
  logic            frame_seen_q, frame_seen_d;
  logic            tvalid_q, tvalid_d;
  logic [2*DW-1:0] tdata_q, tdata_d;
  logic            tlast_q, tlast_d;
  logic            flast_q, flast_d;
  logic            err_align_q, err_align_d;
  logic            err_short_q, err_short_d;

  bin_class_t      cls;
  logic            advance;
  logic            accept;
  logic            last_bin;
  logic            last_data;
  logic            frame_flag;
  logic            emit;
  logic [2*DW-1:0] emit_word;
  logic [2*DW-1:0] pilot_word;
  logic            lfsr_step;
  logic            lfsr_reload;
  logic            lfsr_p_neg;
  logic            pol_neg;

  ofdm_pilot_lfsr u_pilot_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (lfsr_step),
    .reload (lfsr_reload),
    .p_neg  (lfsr_p_neg)
  );

  assign pol_neg = PILOT_POL_EN && lfsr_p_neg;

  always_comb begin
    pilot_word         = '0;
    pilot_word[DW-1:0] = pol_neg ? SYMBOL_NEG : SYMBOL_POS;
  end

  assign cls       = bin_class(32'(b_q), NFFT, NUSED, PILOT_SPACING, PILOT_OFFSET);
  assign advance   = !tvalid_q || m_axis_tready;
  assign last_bin  = (b_q == BW'(NFFT - 1));
  assign last_data = (dcnt_q == DCW'(NDATA - 1));

  assign s_axis_tready = (state_q == RUN) && (cls == BIN_DATA) && advance;
  assign accept        = s_axis_tready && s_axis_tvalid;

  // A frame ends in this symbol if tlast was seen earlier, arrives on this
  // very bin, or the symbol is being padded.
  assign frame_flag = frame_seen_q || (accept && s_axis_tlast) || (state_q == PAD);

  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    dcnt_d       = dcnt_q;
    frame_seen_d = frame_seen_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    flast_d      = flast_q;
    err_align_d  = 1'b0;
    err_short_d  = 1'b0;
    lfsr_step    = 1'b0;
    lfsr_reload  = 1'b0;
    emit         = 1'b0;
    emit_word    = '0;

    // The stage empties whenever it may advance and nothing new is loaded.
    if (advance) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      flast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          state_d = RUN;
        end
      end
      RUN, PAD: begin
        if (advance) begin
          case (cls)
            BIN_NULL: emit = 1'b1;
            BIN_PILOT: begin
              emit      = 1'b1;
              emit_word = pilot_word;
            end
            BIN_DATA: begin
              if (state_q == PAD) begin
                emit = 1'b1;
              end else if (s_axis_tvalid) begin
                emit      = 1'b1;
                emit_word = s_axis_tdata;
              end
            end
            default: emit = 1'b0;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      dcnt_d = dcnt_q + DCW'(1);
      if (s_mod_symb_last != last_data) begin
        err_align_d = 1'b1;
      end
      if (s_axis_tlast) begin
        frame_seen_d = 1'b1;
        if (!last_data) begin
          err_short_d = 1'b1;
          state_d     = PAD;
        end
      end
    end

    if (emit) begin
      tvalid_d = 1'b1;
      tdata_d  = emit_word;
      tlast_d  = last_bin;
      if (last_bin) begin
        b_d          = '0;
        dcnt_d       = '0;
        frame_seen_d = 1'b0;
        state_d      = IDLE;
        flast_d      = frame_flag;
        lfsr_step    = 1'b1;
        lfsr_reload  = frame_flag;
      end else begin
        b_d = b_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      b_q          <= '0;
      dcnt_q       <= '0;
      frame_seen_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      flast_q      <= 1'b0;
      err_align_q  <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      dcnt_q       <= dcnt_d;
      frame_seen_q <= frame_seen_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      flast_q      <= flast_d;
      err_align_q  <= err_align_d;
      err_short_q  <= err_short_d;
    end
  end

  assign m_axis_tvalid     = tvalid_q;
  assign m_axis_tdata      = tdata_q;
  assign m_axis_tlast      = tlast_q;
  assign m_axis_frame_last = flast_q;
  assign err_symb_align    = err_align_q;
  assign err_short_frame   = err_short_q;

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// ----------------------------------------------------------------------------
// tb_ofdm_subcarrier_mapper
// Self-checking bench for ofdm_subcarrier_mapper at default parameters.
// ----------------------------------------------------------------------------
module tb_ofdm_subcarrier_mapper;
  import ofdm_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_mod_symb_last;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_frame_last;
  logic        err_symb_align;
  logic        err_short_frame;

  ofdm_subcarrier_mapper #(
    .NFFT          (64),
    .NUSED         (48),
    .PILOT_SPACING (8),
    .PILOT_OFFSET  (3),
    .DW            (16),
    .SYMBOL_POS    (16'h7FFF),
    .SYMBOL_NEG    (16'h8001),
    .PILOT_POL_EN  (1'b1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tlast      (s_axis_tlast),
    .s_mod_symb_last   (s_mod_symb_last),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_frame_last (m_axis_frame_last),
    .err_symb_align    (err_symb_align),
    .err_short_frame   (err_short_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        flast;
  } exp_t;

  typedef struct {
    int          ndat;
    int          tl_idx;
    int          sl_idx;
    bit          rdy_rand;
    bit          gap_rand;
    logic [15:0] base;
    int          exp_align;
    int          exp_short;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          sym_idx = 0;
  logic [15:0] pol_seq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0 = null, 1 = pilot, 2 = data for the default 64/48 geometry
  function automatic int kind(input int b);
    int pb[6] = '{4, 12, 20, 43, 51, 59};
    if (b == 0 || (b >= 25 && b <= 39)) return 0;
    foreach (pb[i]) if (pb[i] == b) return 1;
    return 2;
  endfunction

  task automatic run_symbol(input int ndat, input int tl_idx, input int sl_idx,
                            input bit rdy_rand, input bit gap_rand,
                            input logic [15:0] base, input int exp_align,
                            input int exp_short, input int stop_after);
    bit          neg;
    bit          flast;
    int          j;
    int          si;
    int          cyc;
    int          popped;
    int          n_align;
    int          n_short;
    bit          acc;
    bit          prev_stall;
    logic [31:0] prev_data;
    exp_t        e;
    exp_t        got;
    cplx_t       c;

    neg   = pol_seq[sym_idx];
    flast = (tl_idx != 0);
    j = 0;
    for (int b = 0; b < 64; b++) begin
      e.last  = (b == 63);
      e.flast = flast && (b == 63);
      case (kind(b))
        0: e.data = 32'h0;
        1: e.data = neg ? 32'h0000_8001 : 32'h0000_7FFF;
        default: begin
          e.data = (j < ndat) ? {base, base + 16'(j + 1)} : 32'h0;
          j++;
        end
      endcase
      sb.push_back(e);
    end

    si = 0; cyc = 0; popped = 0; n_align = 0; n_short = 0;
    acc = 1'b0; prev_stall = 1'b0; prev_data = '0;
    s_axis_tvalid = 1'b0;
    while (sb.size() > 0 && !(stop_after != 0 && popped >= stop_after)) begin
      @(negedge clk);
      if (!s_axis_tvalid || acc) begin
        if (si < ndat && (!gap_rand || $urandom_range(1, 0) == 1)) begin
          c.im = base;
          c.re = base + 16'(si + 1);
          s_axis_tvalid   = 1'b1;
          s_axis_tdata    = c;
          s_axis_tlast    = (si + 1 == tl_idx);
          s_mod_symb_last = (si + 1 == sl_idx);
        end else begin
          s_axis_tvalid   = 1'b0;
          s_axis_tlast    = 1'b0;
          s_mod_symb_last = 1'b0;
        end
      end
      m_axis_tready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      acc = s_axis_tvalid && s_axis_tready;
      if (acc) si++;
      if (prev_stall && m_axis_tvalid)
        check("stall_hold", {32'h0, m_axis_tdata}, {32'h0, prev_data});
      if (m_axis_tvalid && m_axis_tready) begin
        got = sb.pop_front();
        check($sformatf("bin%0d_sym%0d", popped, sym_idx),
              {30'h0, m_axis_tdata, m_axis_tlast, m_axis_frame_last},
              {30'h0, got.data, got.last, got.flast});
        popped++;
      end
      n_align += int'(err_symb_align);
      n_short += int'(err_short_frame);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      cyc++;
      if (cyc > 4000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL timeout: %0d bins outstanding, required 0", sb.size());
        sb.delete();
      end
    end
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    s_mod_symb_last = 1'b0;
    if (stop_after == 0) begin
      repeat (2) begin
        @(negedge clk);
        #1;
        n_align += int'(err_symb_align);
        n_short += int'(err_short_frame);
      end
      check("err_symb_align_count", 64'(n_align), 64'(exp_align));
      check("err_short_frame_count", 64'(n_short), 64'(exp_short));
      sym_idx = flast ? 0 : sym_idx + 1;
    end
  endtask

  vec_t vecs[7];

  initial begin
    rst             = 1'b1;
    s_axis_tvalid   = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tlast    = 1'b0;
    s_mod_symb_last = 1'b0;
    m_axis_tready   = 1'b1;
    pol_seq         = 16'b0100_1111_0111_0000;

    //         ndat tl  sl  rdy gap base      align short
    vecs[0] = '{42,  0, 42, 0, 0, 16'd0,   0, 0};
    vecs[1] = '{42,  0, 42, 1, 1, 16'd100, 0, 0};
    vecs[2] = '{42,  0, 41, 0, 0, 16'd200, 2, 0};
    vecs[3] = '{42,  0,  0, 1, 0, 16'd300, 1, 0};
    vecs[4] = '{30, 30,  0, 0, 1, 16'd400, 0, 1};
    vecs[5] = '{42, 42, 42, 1, 1, 16'd500, 0, 0};
    vecs[6] = '{ 1,  1,  0, 1, 0, 16'd600, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {26'h0, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_frame_last,
                          err_symb_align, err_short_frame, s_axis_tready}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_symbol(vecs[i].ndat, vecs[i].tl_idx, vecs[i].sl_idx, vecs[i].rdy_rand,
                 vecs[i].gap_rand, vecs[i].base, vecs[i].exp_align, vecs[i].exp_short, 0);

    // Full 8-symbol frame: polarity runs through +,+,+,+,-,-,-,+
    for (int i = 0; i < 8; i++)
      run_symbol(42, (i == 7) ? 42 : 0, 42, i[0], 1'b0, 16'(1000 + i * 50), 0, 0, 0);

    // Next frame restarts polarity, then advance into the negative region
    for (int i = 0; i < 4; i++)
      run_symbol(42, 0, 42, 1'b0, 1'b1, 16'(2000 + i * 50), 0, 0, 0);

    // Reset while bin 20 of a -1 polarity symbol is in flight
    run_symbol(42, 0, 42, 1'b0, 1'b0, 16'd3000, 0, 0, 20);
    @(negedge clk);
    rst           = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    check("mid_symbol_reset", {26'h0, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_frame_last,
                               err_symb_align, err_short_frame, s_axis_tready}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sym_idx = 0;
    run_symbol(42, 0, 42, 1'b0, 1'b0, 16'd4000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
